// File: rtl/regfile_wb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_pkg
// Shared definitions for the register-file write-back arbiter.
//   REG_ADDR_WIDTH : width of an architectural register address (x0..x31)
//   WB_DATA_WIDTH  : default result width
//   wb_entry_t     : one buffered write-back {waddr, wdata}
// ---------------------------------------------------------------------------
package regfile_wb_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int WB_DATA_WIDTH  = 64;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] waddr;
        logic [WB_DATA_WIDTH-1:0]  wdata;
    } wb_entry_t;

    // Round-robin successor of a source index in a ring of n sources.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// ---------------------------------------------------------------------------
// wb_arb_fifo
// Per-source write-back buffer: a small circular FIFO with registered
// full/empty flags. A push is honoured when not full, or when full and a
// pop happens in the same cycle (occupancy unchanged).
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (empties the FIFO)
//   clr_i   : synchronous flush (empties the FIFO)
//   push_i  : enqueue data_i
//   data_i  : entry to enqueue
//   pop_i   : dequeue the head
//   data_o  : current head entry
//   empty_o : no entries held
//   full_o  : DEPTH entries held
// ---------------------------------------------------------------------------
module wb_arb_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == CNT_W'(0));
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset and flush both empty the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i && !clr_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Collects results from NR_WB_SOURCES functional units into per-source
// FIFOs and grants up to NR_WRITE_PORTS FIFO heads per cycle onto the
// register-file write ports, scanning round-robin from pointer rr and
// skipping heads whose destination matches an earlier grant of the cycle.
// Writes come only from buffered (registered) state, so an accepted entry
// is written at the earliest the following cycle.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (priority over clr_i)
//   clr_i   : synchronous flush of all FIFOs and rr
//   valid_i : per-source result valid
//   ready_o : per-source accept (FIFO not full)
//   waddr_i : per-source destination register, 5 bits each
//   wdata_i : per-source result, DATA_WIDTH bits each
//   waddr_o : per-port write address (zero when not enabled)
//   wdata_o : per-port write data (zero when not enabled)
//   we_o    : per-port write enable
// Build option:
//   REGFILE_WB_ARB_ZERO_FILTER_EN : entries targeting x0 are handshaken but
//   discarded instead of being buffered and written.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int NR_WB_SOURCES  = 4,
    parameter int NR_WRITE_PORTS = 2,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     clr_i,
    input  logic [NR_WB_SOURCES-1:0]                 valid_i,
    output logic [NR_WB_SOURCES-1:0]                 ready_o,
    input  logic [NR_WB_SOURCES*REG_ADDR_WIDTH-1:0]  waddr_i,
    input  logic [NR_WB_SOURCES*DATA_WIDTH-1:0]      wdata_i,
    output logic [NR_WRITE_PORTS*REG_ADDR_WIDTH-1:0] waddr_o,
    output logic [NR_WRITE_PORTS*DATA_WIDTH-1:0]     wdata_o,
    output logic [NR_WRITE_PORTS-1:0]                we_o
);

    localparam int ENTRY_W = REG_ADDR_WIDTH + DATA_WIDTH;
    localparam int SRC_W   = (NR_WB_SOURCES > 1) ? $clog2(NR_WB_SOURCES) : 1;

    logic [NR_WB_SOURCES-1:0]  push_s;
    logic [NR_WB_SOURCES-1:0]  pop_s;
    logic [NR_WB_SOURCES-1:0]  empty_s;
    logic [NR_WB_SOURCES-1:0]  full_s;
    logic [REG_ADDR_WIDTH-1:0] head_addr_s [NR_WB_SOURCES];
    logic [DATA_WIDTH-1:0]     head_data_s [NR_WB_SOURCES];

    logic [SRC_W-1:0] rr_q, rr_d;
    logic [SRC_W-1:0] cand;
    logic [SRC_W-1:0] last_src;
    logic             granted;
    logic             found;
    logic             conflict;

    logic [NR_WRITE_PORTS-1:0]                we_s;
    logic [NR_WRITE_PORTS*REG_ADDR_WIDTH-1:0] waddr_s;
    logic [NR_WRITE_PORTS*DATA_WIDTH-1:0]     wdata_s;

    // Accept depends only on registered occupancy.
    assign ready_o = ~full_s;

    for (genvar s = 0; s < NR_WB_SOURCES; s++) begin : g_src
        logic [REG_ADDR_WIDTH-1:0] in_addr;
        logic [ENTRY_W-1:0]        head;

        assign in_addr = waddr_i[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
`ifdef REGFILE_WB_ARB_ZERO_FILTER_EN
        // x0 writes complete the handshake but never enter the buffer.
        assign push_s[s] = valid_i[s] & ~full_s[s] & (in_addr != REG_ADDR_WIDTH'(0));
`else
        assign push_s[s] = valid_i[s] & ~full_s[s];
`endif

        wb_arb_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr_i   (clr_i),
            .push_i  (push_s[s]),
            .data_i  ({in_addr, wdata_i[s*DATA_WIDTH +: DATA_WIDTH]}),
            .pop_i   (pop_s[s]),
            .data_o  (head),
            .empty_o (empty_s[s]),
            .full_o  (full_s[s])
        );

        assign head_addr_s[s] = head[ENTRY_W-1 -: REG_ADDR_WIDTH];
        assign head_data_s[s] = head[DATA_WIDTH-1:0];
    end

    // Grant selection: port p takes the first head in rr order that is not
    // yet granted and whose address differs from every earlier port of the
    // cycle. Filling ports in scan order makes the last filled port hold the
    // last granted source, which rr then steps past.
    always_comb begin
        we_s     = '0;
        waddr_s  = '0;
        wdata_s  = '0;
        pop_s    = '0;
        last_src = rr_q;
        granted  = 1'b0;
        found    = 1'b0;
        conflict = 1'b0;
        cand     = rr_q;
        for (int p = 0; p < NR_WRITE_PORTS; p++) begin
            found = 1'b0;
            cand  = rr_q;
            for (int i = 0; i < NR_WB_SOURCES; i++) begin
                if (!found && !empty_s[cand] && !pop_s[cand]) begin
                    conflict = 1'b0;
                    for (int q = 0; q < p; q++) begin
                        conflict = conflict | (we_s[q] &
                            (waddr_s[q*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == head_addr_s[cand]));
                    end
                    if (!conflict) begin
                        found       = 1'b1;
                        granted     = 1'b1;
                        last_src    = cand;
                        pop_s[cand] = 1'b1;
                        we_s[p]     = 1'b1;
                        waddr_s[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] = head_addr_s[cand];
                        wdata_s[p*DATA_WIDTH +: DATA_WIDTH]         = head_data_s[cand];
                    end else begin
                        found = 1'b0;
                    end
                end else begin
                    conflict = 1'b0;
                end
                cand = (cand == SRC_W'(NR_WB_SOURCES - 1)) ? SRC_W'(0) : cand + SRC_W'(1);
            end
        end

        if (granted) begin
            rr_d = SRC_W'(rr_next(32'(last_src), NR_WB_SOURCES));
        end else begin
            rr_d = rr_q;
        end

        // Reset and flush suppress every write and dequeue of the cycle.
        if (rst_i || clr_i) begin
            we_s    = '0;
            waddr_s = '0;
            wdata_s = '0;
            pop_s   = '0;
            rr_d    = '0;
        end else begin
            rr_d = rr_d;
        end
    end

    assign we_o    = we_s;
    assign waddr_o = waddr_s;
    assign wdata_o = wdata_s;

    // Round-robin pointer register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int DW = 64;
    localparam int NS = 4;
    localparam int NW = 2;
    localparam int FD = 2;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            clr_i = 1'b0;
    logic [NS-1:0]   valid_i;
    logic [NS-1:0]   ready_o;
    logic [NS*5-1:0] waddr_i;
    logic [NS*DW-1:0] wdata_i;
    logic [NW*5-1:0] waddr_o;
    logic [NW*DW-1:0] wdata_o;
    logic [NW-1:0]   we_o;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter #(
        .DATA_WIDTH     (DW),
        .NR_WB_SOURCES  (NS),
        .NR_WRITE_PORTS (NW),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clr_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .waddr_i (waddr_i),
        .wdata_i (wdata_i),
        .waddr_o (waddr_o),
        .wdata_o (wdata_o),
        .we_o    (we_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [4:0] pa(input int p);
        return waddr_o[p*5 +: 5];
    endfunction

    function automatic logic [DW-1:0] pd(input int p);
        return wdata_o[p*DW +: DW];
    endfunction

    task automatic clear_inputs();
        valid_i = '0;
        waddr_i = '0;
        wdata_i = '0;
    endtask

    task automatic put(input int s, input logic [4:0] addr, input logic [DW-1:0] data);
        valid_i[s] = 1'b1;
        waddr_i[s*5 +: 5] = addr;
        wdata_i[s*DW +: DW] = data;
    endtask

    // Advance to just after the next rising edge (start of a new cycle).
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Move to the falling edge, where outputs of the current cycle are stable.
    task automatic settle();
        #4;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clr_i = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        valid_i = 4'b1111;
        next_cycle();
        settle();
        n_cmp++; if (we_o !== 2'b00) begin n_err++; $display("FAIL rst_we: got %b want 00", we_o); end
        n_cmp++; if (waddr_o !== 10'd0) begin n_err++; $display("FAIL rst_waddr: got %h want 0", waddr_o); end
        n_cmp++; if (wdata_o !== 128'd0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", wdata_o); end
        next_cycle();
        rst_i = 1'b0;
        clear_inputs();
        settle();
        n_cmp++; if (ready_o !== 4'b1111) begin n_err++; $display("FAIL rst_ready: got %b want 1111", ready_o); end
        n_cmp++; if (we_o !== 2'b00) begin n_err++; $display("FAIL rst_we_after: got %b want 00", we_o); end
    endtask

    task automatic test_single();
        do_reset();
        put(2, 5'd5, 64'hAA);
        settle();
        n_cmp++; if (we_o !== 2'b00) begin n_err++; $display("FAIL single_c0_we: got %b want 00", we_o); end
        next_cycle();
        clear_inputs();
        settle();
        n_cmp++; if (we_o !== 2'b01) begin n_err++; $display("FAIL single_we: got %b want 01", we_o); end
        n_cmp++; if (pa(0) !== 5'd5) begin n_err++; $display("FAIL single_addr: got %0d want 5", pa(0)); end
        n_cmp++; if (pd(0) !== 64'hAA) begin n_err++; $display("FAIL single_data: got %h want aa", pd(0)); end
        n_cmp++; if (pa(1) !== 5'd0 || pd(1) !== 64'd0) begin n_err++; $display("FAIL single_idle_port: got %0d/%h want 0/0", pa(1), pd(1)); end
        next_cycle();
        settle();
        n_cmp++; if (we_o !== 2'b00) begin n_err++; $display("FAIL single_c2_we: got %b want 00", we_o); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int s = 0; s < NS; s++) put(s, 5'(s + 1), 64'h100 + 64'(s));
        settle();
        n_cmp++; if (we_o !== 2'b00) begin n_err++; $display("FAIL rr_c0_we: got %b want 00", we_o); end
        next_cycle();
        clear_inputs();
        settle();
        n_cmp++; if (we_o !== 2'b11) begin n_err++; $display("FAIL rr_c1_we: got %b want 11", we_o); end
        n_cmp++; if (pa(0) !== 5'd1 || pd(0) !== 64'h100) begin n_err++; $display("FAIL rr_c1_p0: got %0d/%h want 1/100", pa(0), pd(0)); end
        n_cmp++; if (pa(1) !== 5'd2 || pd(1) !== 64'h101) begin n_err++; $display("FAIL rr_c1_p1: got %0d/%h want 2/101", pa(1), pd(1)); end
        next_cycle();
        settle();
        n_cmp++; if (we_o !== 2'b11) begin n_err++; $display("FAIL rr_c2_we: got %b want 11", we_o); end
        n_cmp++; if (pa(0) !== 5'd3 || pd(0) !== 64'h102) begin n_err++; $display("FAIL rr_c2_p0: got %0d/%h want 3/102", pa(0), pd(0)); end
        n_cmp++; if (pa(1) !== 5'd4 || pd(1) !== 64'h103) begin n_err++; $display("FAIL rr_c2_p1: got %0d/%h want 4/103", pa(1), pd(1)); end
        next_cycle();
        put(0, 5'd9, 64'h109);
        put(3, 5'd10, 64'h10A);
        settle();
        n_cmp++; if (we_o !== 2'b00) begin n_err++; $display("FAIL rr_c3_we: got %b want 00", we_o); end
        next_cycle();
        clear_inputs();
        settle();
        // rr back at 0: source 0 must take port 0 ahead of source 3.
        n_cmp++; if (we_o !== 2'b11) begin n_err++; $display("FAIL rr_wrap_we: got %b want 11", we_o); end
        n_cmp++; if (pa(0) !== 5'd9 || pa(1) !== 5'd10) begin n_err++; $display("FAIL rr_wrap_order: got %0d,%0d want 9,10", pa(0), pa(1)); end
    endtask

    task automatic test_conflict();
        do_reset();
        put(0, 5'd7, 64'hA0);
        put(1, 5'd7, 64'hA1);
        next_cycle();
        clear_inputs();
        settle();
        n_cmp++; if (we_o !== 2'b01) begin n_err++; $display("FAIL conf_c1_we: got %b want 01", we_o); end
        n_cmp++; if (pa(0) !== 5'd7 || pd(0) !== 64'hA0) begin n_err++; $display("FAIL conf_c1_p0: got %0d/%h want 7/a0", pa(0), pd(0)); end
        next_cycle();
        settle();
        n_cmp++; if (we_o !== 2'b01) begin n_err++; $display("FAIL conf_c2_we: got %b want 01", we_o); end
        n_cmp++; if (pa(0) !== 5'd7 || pd(0) !== 64'hA1) begin n_err++; $display("FAIL conf_c2_p0: got %0d/%h want 7/a1", pa(0), pd(0)); end
        next_cycle();
        settle();
        n_cmp++; if (we_o !== 2'b00) begin n_err++; $display("FAIL conf_c3_we: got %b want 00", we_o); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        put(1, 5'd2, 64'h21);
        next_cycle();
        clear_inputs();
        put(0, 5'd1, 64'hE0);
        put(2, 5'd3, 64'h31);
        put(3, 5'd4, 64'h41);
        settle();
        n_cmp++; if (we_o !== 2'b01 || pd(0) !== 64'h21) begin n_err++; $display("FAIL bp_c1: got %b/%h want 01/21", we_o, pd(0)); end
        next_cycle();
        clear_inputs();
        put(0, 5'd1, 64'hE1);
        settle();
        n_cmp++; if (ready_o !== 4'b1111) begin n_err++; $display("FAIL bp_c2_ready: got %b want 1111", ready_o); end
        n_cmp++; if (we_o !== 2'b11 || pd(0) !== 64'h31 || pd(1) !== 64'h41) begin n_err++; $display("FAIL bp_c2: got %b/%h/%h want 11/31/41", we_o, pd(0), pd(1)); end
        next_cycle();
        clear_inputs();
        put(0, 5'd1, 64'hE2);
        settle();
        n_cmp++; if (ready_o !== 4'b1110) begin n_err++; $display("FAIL bp_c3_ready: got %b want 1110", ready_o); end
        n_cmp++; if (we_o !== 2'b01 || pd(0) !== 64'hE0) begin n_err++; $display("FAIL bp_c3: got %b/%h want 01/e0", we_o, pd(0)); end
        next_cycle();
        settle();
        n_cmp++; if (ready_o !== 4'b1111) begin n_err++; $display("FAIL bp_c4_ready: got %b want 1111", ready_o); end
        n_cmp++; if (we_o !== 2'b01 || pd(0) !== 64'hE1) begin n_err++; $display("FAIL bp_c4: got %b/%h want 01/e1", we_o, pd(0)); end
        next_cycle();
        clear_inputs();
        settle();
        n_cmp++; if (we_o !== 2'b01 || pd(0) !== 64'hE2) begin n_err++; $display("FAIL bp_c5: got %b/%h want 01/e2", we_o, pd(0)); end
        next_cycle();
        settle();
        n_cmp++; if (we_o !== 2'b00) begin n_err++; $display("FAIL bp_c6_we: got %b want 00", we_o); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int s = 0; s < NS; s++) put(s, 5'd9, 64'h90 + 64'(s));
        next_cycle();
        clear_inputs();
        put(0, 5'd9, 64'h98);
        put(1, 5'd9, 64'h99);
        settle();
        n_cmp++; if (we_o !== 2'b01 || pd(0) !== 64'h90) begin n_err++; $display("FAIL flush_pre: got %b/%h want 01/90", we_o, pd(0)); end
        next_cycle();
        clear_inputs();
        clr_i = 1'b1;
        for (int s = 0; s < NS; s++) put(s, 5'd12, 64'hC0);
        settle();
        n_cmp++; if (ready_o !== 4'b1101) begin n_err++; $display("FAIL flush_full: got %b want 1101", ready_o); end
        n_cmp++; if (we_o !== 2'b00 || waddr_o !== 10'd0) begin n_err++; $display("FAIL flush_clr_we: got %b/%h want 00/0", we_o, waddr_o); end
        next_cycle();
        clr_i = 1'b0;
        clear_inputs();
        settle();
        n_cmp++; if (ready_o !== 4'b1111) begin n_err++; $display("FAIL flush_ready: got %b want 1111", ready_o); end
        n_cmp++; if (we_o !== 2'b00) begin n_err++; $display("FAIL flush_c3_we: got %b want 00", we_o); end
        next_cycle();
        settle();
        n_cmp++; if (we_o !== 2'b00) begin n_err++; $display("FAIL flush_c4_we: got %b want 00", we_o); end
        next_cycle();
        put(0, 5'd11, 64'hB0);
        put(1, 5'd12, 64'hB1);
        next_cycle();
        clear_inputs();
        settle();
        n_cmp++; if (we_o !== 2'b11 || pa(0) !== 5'd11 || pa(1) !== 5'd12) begin n_err++; $display("FAIL flush_rr0: got %b/%0d/%0d want 11/11/12", we_o, pa(0), pa(1)); end
    endtask

    task automatic test_zero_filter();
        do_reset();
        put(3, 5'd0, 64'h55);
        settle();
        n_cmp++; if (ready_o[3] !== 1'b1) begin n_err++; $display("FAIL zf_ready: got %b want 1", ready_o[3]); end
        next_cycle();
        clear_inputs();
        settle();
`ifdef REGFILE_WB_ARB_ZERO_FILTER_EN
        n_cmp++; if (we_o !== 2'b00) begin n_err++; $display("FAIL zf_dropped: got %b want 00", we_o); end
`else
        n_cmp++; if (we_o !== 2'b01 || pa(0) !== 5'd0 || pd(0) !== 64'h55) begin n_err++; $display("FAIL zf_written: got %b/%0d/%h want 01/0/55", we_o, pa(0), pd(0)); end
`endif
        next_cycle();
        settle();
        n_cmp++; if (we_o !== 2'b00) begin n_err++; $display("FAIL zf_c2_we: got %b want 00", we_o); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int s = 0; s < NS; s++) put(s, 5'(s + 1), 64'h200 + 64'(s));
        next_cycle();
        clear_inputs();
        rst_i = 1'b1;
        clr_i = 1'b1;
        settle();
        n_cmp++; if (we_o !== 2'b00 || wdata_o !== 128'd0) begin n_err++; $display("FAIL mrst_we: got %b/%h want 00/0", we_o, wdata_o); end
        next_cycle();
        rst_i = 1'b0;
        clr_i = 1'b0;
        settle();
        n_cmp++; if (ready_o !== 4'b1111) begin n_err++; $display("FAIL mrst_ready: got %b want 1111", ready_o); end
        n_cmp++; if (we_o !== 2'b00) begin n_err++; $display("FAIL mrst_c2_we: got %b want 00", we_o); end
        next_cycle();
        settle();
        n_cmp++; if (we_o !== 2'b00) begin n_err++; $display("FAIL mrst_c3_we: got %b want 00", we_o); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_conflict();
        test_back_pressure();
        test_flush();
        test_zero_filter();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
